// File: rtl/mem_ctrl_if.sv
// Request, response and byte-port signals between the load/store buffer, fetch unit,
// memory controller and the 8-bit RAM/IO port.
interface mem_ctrl_if;
  logic        rdy;
  logic        flush;
  logic        io_buffer_full;
  logic        lsb_rd_req;
  logic        lsb_wr_req;
  logic [5:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_rd_done;
  logic [31:0] lsb_rd_data;
  logic        wq_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport master (
    output rdy, flush, io_buffer_full, lsb_rd_req, lsb_wr_req, lsb_len, lsb_addr,
           lsb_wdata, if_req, if_addr, mem_din,
    input  lsb_rd_done, lsb_rd_data, wq_full, if_done, if_data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy, flush, io_buffer_full, lsb_rd_req, lsb_wr_req, lsb_len, lsb_addr,
           lsb_wdata, if_req, if_addr, mem_din,
    output lsb_rd_done, lsb_rd_data, wq_full, if_done, if_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: queued stores first, then loads, then fetches; n-cycle reads.
// Store pulses are never backpressured (dropped when the queue is full); rdy=0 freezes everything.
module mem_ctrl #(
  parameter int WQ_DEPTH = 4,
  parameter int WQ_LOG   = 2
) (
  input logic      clk,
  input logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_L, READ_I, DONE} state_t;

  state_t            state_q;
  logic [31:0]       wq_addr_q [WQ_DEPTH];
  logic [31:0]       wq_data_q [WQ_DEPTH];
  logic [2:0]        wq_nb_q   [WQ_DEPTH];
  logic [WQ_LOG-1:0] head_q, tail_q;
  logic [WQ_LOG:0]   count_q;

  logic [31:0] cur_addr_q, cur_data_q, rbuf_q, rbuf_d;
  logic [2:0]  nb_q, cnt_q;
  logic [1:0]  byte_sel;
  logic [31:0] mem_a_q, lsb_rd_data_q, if_data_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q, lsb_rd_done_q, if_done_q;

  logic wq_empty, wq_full_w, io_stall, push, pop;

  function automatic logic [2:0] len2nb(input logic [5:0] len);
    case (len)
      6'd8:    return 3'd1;
      6'd16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign wq_empty  = (count_q == '0);
  assign wq_full_w = (count_q == (WQ_LOG+1)'(WQ_DEPTH));
  // IO writes to the UART window wait for buffer space; everything behind them waits too.
  assign io_stall  = (wq_addr_q[head_q][17:16] == 2'b11) && bus.io_buffer_full;
  assign push      = bus.lsb_wr_req && !wq_full_w;
  assign pop       = (state_q == IDLE) && !wq_empty && !io_stall;

  assign byte_sel = cnt_q[1:0] - 2'd1;
  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[{byte_sel, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (bus.rdy && push) begin
      wq_addr_q[tail_q] <= bus.lsb_addr;
      wq_data_q[tail_q] <= bus.lsb_wdata;
      wq_nb_q[tail_q]   <= len2nb(bus.lsb_len);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.rdy) begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      nb_q          <= '0;
      cur_addr_q    <= '0;
      cur_data_q    <= '0;
      rbuf_q        <= '0;
      mem_a_q       <= '0;
      mem_dout_q    <= '0;
      mem_wr_q      <= 1'b0;
      lsb_rd_done_q <= 1'b0;
      lsb_rd_data_q <= '0;
      if_done_q     <= 1'b0;
      if_data_q     <= '0;
    end else if (bus.rdy) begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            cur_addr_q <= wq_addr_q[head_q];
            cur_data_q <= wq_data_q[head_q];
            nb_q       <= wq_nb_q[head_q];
            mem_a_q    <= wq_addr_q[head_q];
            mem_dout_q <= wq_data_q[head_q][7:0];
            mem_wr_q   <= 1'b1;
            cnt_q      <= 3'd1;
            state_q    <= WRITE;
          end else if (wq_empty && bus.lsb_rd_req) begin
            cur_addr_q <= bus.lsb_addr;
            mem_a_q    <= bus.lsb_addr;
            nb_q       <= len2nb(bus.lsb_len);
            rbuf_q     <= '0;
            cnt_q      <= 3'd1;
            state_q    <= READ_L;
          end else if (wq_empty && bus.if_req) begin
            cur_addr_q <= bus.if_addr;
            mem_a_q    <= bus.if_addr;
            nb_q       <= 3'd4;
            rbuf_q     <= '0;
            cnt_q      <= 3'd1;
            state_q    <= READ_I;
          end
        end
        WRITE: begin
          if (cnt_q == nb_q) begin
            mem_wr_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            mem_a_q    <= cur_addr_q + 32'(cnt_q);
            mem_dout_q <= cur_data_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_q      <= cnt_q + 3'd1;
          end
        end
        READ_L, READ_I: begin
          if (bus.flush) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rbuf_q <= rbuf_d;
            if (cnt_q == nb_q) begin
              if (state_q == READ_L) begin
                lsb_rd_done_q <= 1'b1;
                lsb_rd_data_q <= rbuf_d;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= rbuf_d;
              end
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              mem_a_q <= cur_addr_q + 32'(cnt_q);
              cnt_q   <= cnt_q + 3'd1;
            end
          end
        end
        DONE: begin
          lsb_rd_done_q <= 1'b0;
          if_done_q     <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.lsb_rd_done = lsb_rd_done_q;
  assign bus.lsb_rd_data = lsb_rd_data_q;
  assign bus.if_done     = if_done_q;
  assign bus.if_data     = if_data_q;
  assign bus.wq_full     = wq_full_w;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the load/store buffer; also serves the instruction-fetch unit.
- Converts 32-bit load/store/fetch requests into byte-serial accesses on the single 8-bit RAM/IO port.
- Buffers committed stores in a small write queue, because the store-issue pulse is not backpressured.
- Returns assembled load/fetch data as a one-cycle done pulse.

Parameters:
- WQ_DEPTH, 4, number of write-queue entries; must be a power of two, at least 2.
- WQ_LOG, 2, log2(WQ_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rdy  in  1  global ready; when low, all registers hold
- flush  in  1  branch-mispredict flush
- io_buffer_full  in  1  UART buffer full
- lsb_rd_req  in  1  load request level, held until done
- lsb_wr_req  in  1  store pulse, one cycle per store
- lsb_len  in  6  access width in bits: 8, 16 or 32
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, low bytes first
- lsb_rd_done  out  1  load complete pulse
- lsb_rd_data  out  32  load bytes, zero-extended
- wq_full  out  1  write queue full
- if_req  in  1  fetch request level
- if_addr  in  32  fetch address
- if_done  out  1  fetch complete pulse
- if_data  out  32  fetched word
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe; 1 = write

Behaviour:
- Reset (rst=0, async) clears the following: state=IDLE, queue pointers and count, byte counter, all outputs. mem_a=0, mem_wr=0.
- rdy=0: every register holds its value; the cycle does not count.
- Write queue:
  - lsb_wr_req pushes {addr, wdata, nbytes=len/8}; a push while full is dropped.
  - wq_full = (count==WQ_DEPTH).
  - Push and pop in the same edge are both performed.
  - Head and tail pointers wrap modulo WQ_DEPTH.
  - lsb_len values other than 8/16 are treated as 32.
- Arbitration, evaluated in IDLE only:
  - Priority 1: queue non-empty → WRITE.
  - Priority 2: lsb_rd_req → READ_L.
  - Priority 3: if_req → READ_I.
  - Loads never start while the queue is non-empty or a WRITE is in progress; this keeps stores before later loads.
- IO stall: if the queue head has addr[17:16]==2'b11 and io_buffer_full=1, stay in IDLE and issue nothing. Reads still wait behind it.
- WRITE of n bytes:
  - Accept edge E0 drives mem_a=addr, mem_dout=byte0, mem_wr=1, and pops the head.
  - Edge Ek drives addr+k and byte k, for k<n.
  - Edge En drives mem_wr=0 and returns to IDLE.
  - Net cost is n cycles of mem_wr=1.
- READ (L or I), n bytes (fetch n=4):
  - E0 latches the address and drives mem_a=addr, mem_wr=0.
  - Edge Ek drives addr+k for k<n.
  - mem_din at edge E(k+1) is byte k; it is placed in bits [8k+7:8k].
  - At E(n): byte n-1 is captured, the done pulse is asserted with the full data, and the state goes to DONE.
  - Latency is n cycles from accept to done. LW and fetch take 4 cycles; LB takes 1.
- DONE: done pulses drop next edge, then IDLE. lsb_rd_req/if_req are ignored in DONE, so a stale level is not re-served. The data outputs hold their value until the next read completes.
- Flush:
  - In READ_L/READ_I: go to IDLE at the next edge, no done pulse; partial data is discarded.
  - In WRITE or with a non-empty queue: no effect; stores are committed.
  - flush with lsb_wr_req in the same cycle: the push still happens.
  - flush in DONE: the pulse still drops normally.
- Address arithmetic is 32-bit with wrap-around; there is no alignment requirement.
- mem_wr is 0 in every state except WRITE.

Test Plan:
- Store then load: lsb_wr_req SW addr 0x100 data 0xDEADBEEF, next cycle lsb_rd_req LW 0x100. Required: mem_wr=1 for 4 cycles with bytes EF,BE,AD,DE to 0x100..0x103, then the read. lsb_rd_done with 0xDEADBEEF 4 cycles after read accept.
- Byte and half loads: RAM[0x200..0x201]=0x80,0xFF.
  - LB 0x200 → lsb_rd_data=0x00000080 after 1 cycle.
  - LH 0x200 → lsb_rd_data=0x0000FF80 after 2 cycles.
- Queue full: 4 SW pulses on consecutive cycles while a fetch is in progress. Required: wq_full=1 after the 4th. A 5th pulse is dropped. Drain order is FIFO; wq_full falls on the first pop.
- Flush mid-fetch: if_req at 0x1000, flush asserted at byte 2. Required: no if_done, IDLE next edge. A new if_req at 0x2000 completes normally with correct data.
- IO stall: SB to 0x30000 with io_buffer_full=1 for 5 cycles. Required: mem_wr stays 0 and a pending LW waits. After io_buffer_full drops, 1 write cycle, then the LW.
- Async reset during WRITE: rst low mid-word. Required: mem_wr=0 immediately, queue empty, wq_full=0, done outputs 0.
